snake_body_ctrl: RTL and testbench

Sequential initiator for the 64x8 snake-body memory. It keeps one packed head coordinate per memory word. On each game tick it shifts every stored segment one slot toward the tail, optionally grows the body, and writes the new head at address 0. Between ticks it answers single-word lookups for the renderer and collision logic. It is the only master on the memory's read_rq/write_rq/rw_address/write_data port.

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_body_ctrl.sv | 151 +++++++++++++++
 tb/tb_snake_body_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake-body memory controller.
package snake_pkg;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 8;

    // Controller states: IDLE serves lookups, RD/WR shift one segment,
    // HEAD writes the new head word, DONE signals tick completion.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        HEAD = 3'd3,
        DONE = 3'd4
    } state_t;

    // A coordinate word packs x in the upper nibble and y in the lower nibble.
    localparam int X_MSB = 7;
    localparam int X_LSB = 4;
    localparam int Y_MSB = 3;
    localparam int Y_LSB = 0;

    function automatic logic [DW-1:0] pack_xy(input logic [3:0] x, input logic [3:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/snake_body_ctrl.sv
// Snake-body controller: on each tick it moves every stored segment one word
// toward the tail (top address first, so no word is read after being
// overwritten), optionally grows, and writes the new head at address 0.
// While idle it serves single-word lookups with one cycle of latency.
module snake_body_ctrl #(
    parameter int DEPTH = snake_pkg::DEPTH,
    parameter int AW    = snake_pkg::AW,
    parameter int DW    = snake_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          move,
    input  logic          grow,
    input  logic [DW-1:0] new_head,
    input  logic          q_req,
    input  logic [AW-1:0] q_idx,
    output logic          q_valid,
    output logic [DW-1:0] q_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   length,
    output logic          read_rq,
    output logic          write_rq,
    output logic [AW-1:0] rw_address,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data
);

    import snake_pkg::*;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_ptr;
    logic [DW-1:0] r_hold;
    logic [DW-1:0] r_head;
    logic [AW:0]   r_length;
    logic          r_q_valid;
    logic [DW-1:0] r_q_data;

    logic          w_can_grow;
    logic [AW-1:0] w_top;
    logic          w_read_rq;
    logic          w_write_rq;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // Growth is only possible below full depth; at full depth the tail drops.
    assign w_can_grow = grow && (r_length < DEPTH_L);
    assign w_top      = w_can_grow ? r_length[AW-1:0] : AW'(r_length - (AW+1)'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and memory-port drive.
    always_comb begin
        w_state_next = r_state;
        w_read_rq    = 1'b0;
        w_write_rq   = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        case (r_state)
            IDLE: begin
                if (move) begin
                    w_state_next = (w_top == '0) ? HEAD : RD;
                end else if (q_req) begin
                    w_read_rq = 1'b1;
                    w_addr    = q_idx;
                end
            end
            RD: begin
                w_read_rq    = 1'b1;
                w_addr       = r_ptr - ONE_A;
                w_state_next = WR;
            end
            WR: begin
                w_write_rq   = 1'b1;
                w_addr       = r_ptr;
                w_wdata      = r_hold;
                w_state_next = (r_ptr == ONE_A) ? HEAD : RD;
            end
            HEAD: begin
                w_write_rq   = 1'b1;
                w_addr       = '0;
                w_wdata      = r_head;
                w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: tick capture, shift pointer, hold word, length, lookup result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_hold    <= '0;
            r_head    <= '0;
            r_length  <= (AW+1)'(1);
            r_q_valid <= 1'b0;
            r_q_data  <= '0;
        end else begin
            r_q_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (move) begin
                        r_head <= new_head;
                        r_ptr  <= w_top;
                        if (w_can_grow) begin
                            r_length <= r_length + (AW+1)'(1);
                        end
                    end else if (q_req) begin
                        r_q_valid <= 1'b1;
                        r_q_data  <= read_data;
                    end
                end
                RD: begin
                    r_hold <= read_data;
                end
                WR: begin
                    r_ptr <= r_ptr - ONE_A;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign length     = r_length;
    assign q_valid    = r_q_valid;
    assign q_data     = r_q_data;
    assign read_rq    = w_read_rq;
    assign write_rq   = w_write_rq;
    assign rw_address = w_addr;
    assign write_data = w_wdata;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl with an inline 64x8 memory acting as the slave.
module tb_snake_body_ctrl;

    logic       clk;
    logic       rst;
    logic       move;
    logic       grow;
    logic [7:0] new_head;
    logic       q_req;
    logic [5:0] q_idx;
    logic       q_valid;
    logic [7:0] q_data;
    logic       busy;
    logic       done;
    logic [6:0] length;
    logic       read_rq;
    logic       write_rq;
    logic [5:0] rw_address;
    logic [7:0] write_data;
    logic [7:0] read_data;

    int tests;
    int fails;
    int collisions;

    logic [7:0] mem [0:63];

    snake_body_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .move       (move),
        .grow       (grow),
        .new_head   (new_head),
        .q_req      (q_req),
        .q_idx      (q_idx),
        .q_valid    (q_valid),
        .q_data     (q_data),
        .busy       (busy),
        .done       (done),
        .length     (length),
        .read_rq    (read_rq),
        .write_rq   (write_rq),
        .rw_address (rw_address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave: async clear on reset, write at the clock edge,
    // combinational read while only read_rq is high.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        end else if (write_rq) begin
            mem[rw_address] <= write_data;
        end
    end
    assign read_data = (read_rq && !write_rq) ? mem[rw_address] : 8'h00;

    // Strobe monitor.
    always @(negedge clk) begin
        if (rst && read_rq && write_rq) collisions++;
    end

    typedef struct {
        logic [7:0] head;
        logic       grow;
        int         exp_len;
        int         exp_cycles;
    } tick_vec_t;

    typedef struct {
        logic [5:0] idx;
        logic [7:0] exp_data;
    } look_vec_t;

    tick_vec_t tick_tab [3];
    look_vec_t look_tab [5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called and returns at 1 time unit after a rising edge.
    // qmode 0: plain tick; 1: q_req together with move; 2: q_req held while busy.
    task automatic do_tick(input logic [7:0] head, input logic g, input int qmode,
                           output int cycles, output int dones, output int qv);
        move     = 1'b1;
        grow     = g;
        new_head = head;
        q_req    = (qmode == 1);
        q_idx    = 6'd0;
        @(posedge clk);
        #1;
        move   = 1'b0;
        grow   = 1'b0;
        q_req  = (qmode == 2);
        cycles = 0;
        dones  = 0;
        qv     = 0;
        while (busy && cycles < 300) begin
            cycles++;
            if (done) dones++;
            if (q_valid) qv++;
            @(posedge clk);
            #1;
        end
        q_req = 1'b0;
        if (q_valid) qv++;
        $display("[TB] tick head=0x%02h grow=%0d qmode=%0d cycles=%0d len=%0d",
                 head, g, qmode, cycles, length);
    endtask

    task automatic lookup(input logic [5:0] idx, output logic [7:0] d, output logic v);
        q_req = 1'b1;
        q_idx = idx;
        @(posedge clk);
        #1;
        q_req = 1'b0;
        d     = q_data;
        v     = q_valid;
        $display("[TB] lookup idx=%0d data=0x%02h valid=%0d", idx, d, v);
    endtask

    initial begin
        int         cyc;
        int         dn;
        int         qv;
        logic [7:0] d;
        logic       v;

        tests      = 0;
        fails      = 0;
        collisions = 0;
        rst        = 1'b0;
        move       = 1'b0;
        grow       = 1'b0;
        new_head   = 8'h00;
        q_req      = 1'b0;
        q_idx      = 6'd0;

        tick_tab[0] = '{8'h11, 1'b1, 2, 4};
        tick_tab[1] = '{8'h12, 1'b1, 3, 6};
        tick_tab[2] = '{8'h13, 1'b1, 4, 8};
        look_tab[0] = '{6'd0,  8'h13};
        look_tab[1] = '{6'd1,  8'h12};
        look_tab[2] = '{6'd2,  8'h11};
        look_tab[3] = '{6'd3,  8'h00};
        look_tab[4] = '{6'd10, 8'h00};

        // Reset state
        apply_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q_valid", q_valid, 0);
        check("rst_q_data", q_data, 0);
        check("rst_read_rq", read_rq, 0);
        check("rst_write_rq", write_rq, 0);
        check("rst_rw_address", rw_address, 0);
        check("rst_write_data", write_data, 0);
        check("rst_length", length, 1);
        lookup(6'd0, d, v);
        check("rst_lookup_valid", v, 1);
        check("rst_lookup_data", d, 8'h00);
        @(posedge clk);
        #1;
        check("q_valid_pulse_ends", q_valid, 0);

        // Length-1 tick
        do_tick(8'h35, 1'b0, 0, cyc, dn, qv);
        check("len1_cycles", cyc, 2);
        check("len1_done_pulses", dn, 1);
        check("len1_length", length, 1);
        lookup(6'd0, d, v);
        check("len1_lookup_valid", v, 1);
        check("len1_lookup_data", d, 8'h35);
        @(posedge clk);
        #1;
        check("q_data_holds", q_data, 8'h35);

        // move and q_req in the same cycle, then q_req while busy
        do_tick(8'h36, 1'b0, 1, cyc, dn, qv);
        check("same_cycle_cycles", cyc, 2);
        check("same_cycle_no_q_valid", qv, 0);
        do_tick(8'h37, 1'b0, 2, cyc, dn, qv);
        check("busy_req_cycles", cyc, 2);
        check("busy_req_no_q_valid", qv, 0);
        lookup(6'd0, d, v);
        check("after_collide_data", d, 8'h37);

        // Grow sequence from a fresh reset
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_tick(tick_tab[i].head, tick_tab[i].grow, 0, cyc, dn, qv);
            check($sformatf("grow%0d_cycles", i), cyc, tick_tab[i].exp_cycles);
            check($sformatf("grow%0d_length", i), length, tick_tab[i].exp_len);
            check($sformatf("grow%0d_done", i), dn, 1);
        end
        for (int i = 0; i < 5; i++) begin
            lookup(look_tab[i].idx, d, v);
            check($sformatf("look_idx%0d_valid", look_tab[i].idx), v, 1);
            check($sformatf("look_idx%0d_data", look_tab[i].idx), d, look_tab[i].exp_data);
        end

        // Grow up to full depth
        for (int i = 0; i < 60; i++) begin
            do_tick(8'h40 + 8'(i), 1'b1, 0, cyc, dn, qv);
            check($sformatf("fill%0d_cycles", i), cyc, 2 * (4 + i) + 2);
            check($sformatf("fill%0d_length", i), length, 5 + i);
        end
        lookup(6'd0, d, v);
        check("full_idx0", d, 8'h7B);
        lookup(6'd59, d, v);
        check("full_idx59", d, 8'h40);
        lookup(6'd60, d, v);
        check("full_idx60", d, 8'h13);
        lookup(6'd63, d, v);
        check("full_idx63", d, 8'h00);

        // Grow request at full depth is ignored; tail word drops
        do_tick(8'hAA, 1'b1, 0, cyc, dn, qv);
        check("sat_cycles", cyc, 128);
        check("sat_length", length, 64);
        check("sat_done", dn, 1);
        lookup(6'd0, d, v);
        check("sat_idx0", d, 8'hAA);
        lookup(6'd1, d, v);
        check("sat_idx1", d, 8'h7B);
        lookup(6'd60, d, v);
        check("sat_idx60", d, 8'h40);
        lookup(6'd63, d, v);
        check("sat_idx63", d, 8'h11);

        // Long tick with q_req held while busy
        do_tick(8'hBB, 1'b0, 2, cyc, dn, qv);
        check("full_busy_req_cycles", cyc, 128);
        check("full_busy_req_no_q_valid", qv, 0);
        lookup(6'd1, d, v);
        check("full_busy_req_idx1", d, 8'hAA);

        // Reset during the first RD cycle of a length-10 tick
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_tick(8'h21 + 8'(i), 1'b1, 0, cyc, dn, qv);
        end
        check("len10_length", length, 10);
        move     = 1'b1;
        grow     = 1'b0;
        new_head = 8'h55;
        @(posedge clk);
        #1;
        move = 1'b0;
        check("rd_busy", busy, 1);
        check("rd_read_rq", read_rq, 1);
        check("rd_address", rw_address, 8);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_read_rq", read_rq, 0);
        check("abort_write_rq", write_rq, 0);
        check("abort_rw_address", rw_address, 0);
        check("abort_length", length, 1);
        check("abort_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        lookup(6'd0, d, v);
        check("abort_mem_idx0", d, 8'h00);
        lookup(6'd8, d, v);
        check("abort_mem_idx8", d, 8'h00);
        do_tick(8'h35, 1'b0, 0, cyc, dn, qv);
        check("post_abort_cycles", cyc, 2);
        check("post_abort_length", length, 1);
        lookup(6'd0, d, v);
        check("post_abort_idx0", d, 8'h35);

        check("strobe_collisions", collisions, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
